// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer for the RV32I core: owns the trap CSRs, decides trap entry,
// MRET return and WFI sleep, and redirects fetch accordingly.
module trap_ctrl #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic [31:0] pc,
    input  logic [15:0] exp_code,
    input  logic        is_mret,
    input  logic        is_wfi,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic        csr_hit,
    output logic [31:0] csr_rdata,
    output logic        trap_kill,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        stall
);

    localparam logic [11:0] AddrMstatus = 12'h300;
    localparam logic [11:0] AddrMie     = 12'h304;
    localparam logic [11:0] AddrMtvec   = 12'h305;
    localparam logic [11:0] AddrMepc    = 12'h341;
    localparam logic [11:0] AddrMcause  = 12'h342;
    localparam logic [11:0] AddrMip     = 12'h344;

    localparam logic [31:0] CauseExtIrq   = 32'h8000_000B;
    localparam logic [31:0] CauseTimerIrq = 32'h8000_0007;
    localparam logic [31:0] AlignMask     = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        StRun,
        StRedir,
        StWait
    } state_e;

    state_e      state_q, state_d;
    logic        status_mie_q, status_mie_d;
    logic        status_mpie_q, status_mpie_d;
    logic        mie_mtie_q, mie_mtie_d;
    logic        mie_meie_q, mie_meie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] rpc_q, rpc_d;
    logic [31:0] wfi_pc_q, wfi_pc_d;

    logic        pend;
    logic        gint;
    logic [31:0] int_cause;
    logic [3:0]  exc_cause;
    logic [31:0] mstatus_val;
    logic [31:0] mie_val;
    logic [31:0] mip_val;

    logic        take_trap;
    logic [31:0] trap_cause;
    logic [31:0] trap_epc;
    logic        csr_write;

    assign mip_val     = {20'b0, irq_ext, 3'b0, irq_timer, 7'b0};
    assign mie_val     = {20'b0, mie_meie_q, 3'b0, mie_mtie_q, 7'b0};
    assign mstatus_val = {19'b0, 2'b11, 3'b0, status_mpie_q, 3'b0, status_mie_q, 3'b0};

    assign pend      = |(mip_val & mie_val);
    assign gint      = pend & status_mie_q;
    assign int_cause = (irq_ext & mie_meie_q) ? CauseExtIrq : CauseTimerIrq;

    // Lowest set exception bit wins; scanning downwards leaves the lowest index last.
    always_comb begin
        exc_cause = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (exp_code[i]) begin
                exc_cause = 4'(i);
            end
        end
    end

    always_comb begin
        csr_hit   = 1'b1;
        csr_rdata = 32'h0;
        case (csr_addr)
            AddrMstatus: csr_rdata = mstatus_val;
            AddrMie:     csr_rdata = mie_val;
            AddrMtvec:   csr_rdata = mtvec_q;
            AddrMepc:    csr_rdata = mepc_q;
            AddrMcause:  csr_rdata = mcause_q;
            AddrMip:     csr_rdata = mip_val;
            default:     csr_hit   = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        status_mie_d  = status_mie_q;
        status_mpie_d = status_mpie_q;
        mie_mtie_d    = mie_mtie_q;
        mie_meie_d    = mie_meie_q;
        mtvec_d       = mtvec_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        rpc_d         = rpc_q;
        wfi_pc_d      = wfi_pc_q;
        trap_kill     = 1'b0;
        take_trap     = 1'b0;
        trap_cause    = 32'h0;
        trap_epc      = 32'h0;
        csr_write     = 1'b0;

        unique case (state_q)
            StRun: begin
                if (inst_valid) begin
                    if (gint) begin
                        take_trap  = 1'b1;
                        trap_kill  = 1'b1;
                        trap_cause = int_cause;
                        trap_epc   = pc & AlignMask;
                    end else if (|exp_code) begin
                        take_trap  = 1'b1;
                        trap_kill  = 1'b1;
                        trap_cause = {28'b0, exc_cause};
                        trap_epc   = pc & AlignMask;
                    end else if (is_mret) begin
                        status_mie_d  = status_mpie_q;
                        status_mpie_d = 1'b1;
                        rpc_d         = mepc_q;
                        state_d       = StRedir;
                    end else begin
                        // A WFI with an interrupt already pending falls through as a NOP.
                        if (is_wfi && !pend) begin
                            state_d  = StWait;
                            wfi_pc_d = pc;
                        end
                        csr_write = csr_we;
                    end
                end
            end
            StRedir: begin
                state_d = StRun;
            end
            StWait: begin
                if (pend) begin
                    if (status_mie_q) begin
                        take_trap  = 1'b1;
                        trap_cause = int_cause;
                        trap_epc   = (wfi_pc_q + 32'd4) & AlignMask;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase

        if (csr_write) begin
            case (csr_addr)
                AddrMstatus: begin
                    status_mie_d  = csr_wdata[3];
                    status_mpie_d = csr_wdata[7];
                end
                AddrMie: begin
                    mie_mtie_d = csr_wdata[7];
                    mie_meie_d = csr_wdata[11];
                end
                AddrMtvec:  mtvec_d  = csr_wdata & AlignMask;
                AddrMepc:   mepc_d   = csr_wdata & AlignMask;
                AddrMcause: mcause_d = csr_wdata;
                default: ;
            endcase
        end

        if (take_trap) begin
            mcause_d      = trap_cause;
            mepc_d        = trap_epc;
            status_mpie_d = status_mie_q;
            status_mie_d  = 1'b0;
            rpc_d         = mtvec_q;
            state_d       = StRedir;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StRun;
            status_mie_q  <= 1'b0;
            status_mpie_q <= 1'b0;
            mie_mtie_q    <= 1'b0;
            mie_meie_q    <= 1'b0;
            mtvec_q       <= RESET_MTVEC & AlignMask;
            mepc_q        <= 32'h0;
            mcause_q      <= 32'h0;
            rpc_q         <= 32'h0;
            wfi_pc_q      <= 32'h0;
        end else begin
            state_q       <= state_d;
            status_mie_q  <= status_mie_d;
            status_mpie_q <= status_mpie_d;
            mie_mtie_q    <= mie_mtie_d;
            mie_meie_q    <= mie_meie_d;
            mtvec_q       <= mtvec_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            rpc_q         <= rpc_d;
            wfi_pc_q      <= wfi_pc_d;
        end
    end

    assign redirect    = (state_q == StRedir);
    assign stall       = (state_q == StWait);
    assign redirect_pc = rpc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: CSR vector table, directed trap/MRET/WFI/reset sequences and
// randomized traffic checked against a behavioural model of the trap rules.
module tb_trap_ctrl;

    localparam logic [31:0] RstVec = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [15:0] exp_code;
    logic        is_mret, is_wfi, irq_ext, irq_timer, csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_hit, trap_kill, redirect, stall;
    logic [31:0] csr_rdata, redirect_pc;

    always #5 clk = ~clk;

    trap_ctrl #(.RESET_MTVEC(RstVec)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .exp_code   (exp_code),
        .is_mret    (is_mret),
        .is_wfi     (is_wfi),
        .irq_ext    (irq_ext),
        .irq_timer  (irq_timer),
        .csr_we     (csr_we),
        .csr_addr   (csr_addr),
        .csr_wdata  (csr_wdata),
        .csr_hit    (csr_hit),
        .csr_rdata  (csr_rdata),
        .trap_kill  (trap_kill),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .stall      (stall)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: architectural CSR fields plus "redirecting" and "asleep" flags.
    bit          m_mie, m_mpie, m_mtie, m_meie, m_redir, m_wait;
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_rpc, m_wfi_pc;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        bit          hit;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_mie = 0; m_mpie = 0; m_mtie = 0; m_meie = 0; m_redir = 0; m_wait = 0;
        m_mtvec = RstVec; m_mepc = 0; m_mcause = 0; m_rpc = 0; m_wfi_pc = 0;
    endtask

    function automatic bit m_pend();
        return (irq_timer && m_mtie) || (irq_ext && m_meie);
    endfunction

    function automatic logic [31:0] m_icause();
        return (irq_ext && m_meie) ? 32'h8000_000B : 32'h8000_0007;
    endfunction

    function automatic logic [31:0] m_lowest(input logic [15:0] e);
        for (int i = 0; i < 16; i++) if (e[i]) return i;
        return 0;
    endfunction

    task automatic m_read(input logic [11:0] a, output bit hit, output logic [31:0] d);
        hit = 1;
        case (a)
            12'h300: d = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h304: d = (32'(m_meie) << 11) | (32'(m_mtie) << 7);
            12'h305: d = m_mtvec;
            12'h341: d = m_mepc;
            12'h342: d = m_mcause;
            12'h344: d = (32'(irq_ext) << 11) | (32'(irq_timer) << 7);
            default: begin hit = 0; d = 0; end
        endcase
    endtask

    task automatic m_write(input logic [11:0] a, input logic [31:0] d);
        case (a)
            12'h300: begin m_mie = d[3]; m_mpie = d[7]; end
            12'h304: begin m_mtie = d[7]; m_meie = d[11]; end
            12'h305: m_mtvec = d & ~32'h3;
            12'h341: m_mepc = d & ~32'h3;
            12'h342: m_mcause = d;
            default: ;
        endcase
    endtask

    task automatic m_enter(input logic [31:0] epc, input logic [31:0] cause);
        m_mpie = m_mie; m_mie = 0; m_mcause = cause; m_mepc = epc & ~32'h3;
        m_rpc = m_mtvec; m_redir = 1;
    endtask

    // Check every output against the model, advance the model, then take one clock edge.
    task automatic cycle();
        bit          hit, kill, pend;
        logic [31:0] rd;
        #1;
        pend = m_pend();
        kill = !m_redir && !m_wait && inst_valid && ((pend && m_mie) || exp_code != 0);
        m_read(csr_addr, hit, rd);
        chk("trap_kill", trap_kill, kill);
        chk("csr_hit", csr_hit, hit);
        chk("csr_rdata", csr_rdata, rd);
        chk("redirect", redirect, m_redir);
        chk("stall", stall, m_wait);
        if (m_redir) chk("redirect_pc", redirect_pc, m_rpc);
        if (m_redir) begin
            m_redir = 0;
        end else if (m_wait) begin
            if (pend) begin
                m_wait = 0;
                if (m_mie) m_enter(m_wfi_pc + 4, m_icause());
            end
        end else if (inst_valid) begin
            if (pend && m_mie) m_enter(pc, m_icause());
            else if (exp_code != 0) m_enter(pc, m_lowest(exp_code));
            else if (is_mret) begin
                m_mie = m_mpie; m_mpie = 1; m_rpc = m_mepc; m_redir = 1;
            end else begin
                if (is_wfi && !pend) begin m_wait = 1; m_wfi_pc = pc; end
                if (csr_we) m_write(csr_addr, csr_wdata);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_valid = 0; pc = 0; exp_code = 0; is_mret = 0; is_wfi = 0;
        csr_we = 0; csr_addr = 0; csr_wdata = 0;
    endtask

    task automatic do_reset();
        idle(); irq_ext = 0; irq_timer = 0;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        m_reset();
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        idle(); inst_valid = 1; csr_we = 1; csr_addr = a; csr_wdata = d;
        cycle();
        idle();
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
        idle(); csr_addr = a;
        #1;
        chk(name, csr_rdata, exp);
    endtask

    logic [11:0] addrs[7] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h7FF};

    initial begin
        idle(); irq_ext = 0; irq_timer = 0; rst = 1;
        m_reset();
        #12;
        do_reset();

        // Reset state
        #1;
        chk("rst_redirect", redirect, 0);
        chk("rst_stall", stall, 0);
        chk("rst_rpc", redirect_pc, 0);
        rd("rst_mtvec", 12'h305, 32'h100);
        rd("rst_mstatus", 12'h300, 32'h1800);
        cycle();
        rd("rst_mie", 12'h304, 0);
        rd("rst_mepc", 12'h341, 0);
        rd("rst_mcause", 12'h342, 0);
        cycle();

        // CSR field masking table
        vecs[0] = '{12'h300, 32'hFFFF_FFFF, 1'b1, 32'h0000_1888};
        vecs[1] = '{12'h300, 32'h0000_0000, 1'b1, 32'h0000_1800};
        vecs[2] = '{12'h304, 32'hFFFF_FFFF, 1'b1, 32'h0000_0880};
        vecs[3] = '{12'h305, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFC};
        vecs[4] = '{12'h341, 32'h0000_0007, 1'b1, 32'h0000_0004};
        vecs[5] = '{12'h342, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
        vecs[6] = '{12'h344, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
        vecs[7] = '{12'h123, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
        for (int i = 0; i < 8; i++) begin
            wr(vecs[i].addr, vecs[i].wdata);
            rd("vec_rdata", vecs[i].addr, vecs[i].rdata);
            chk("vec_hit", csr_hit, vecs[i].hit);
        end
        irq_ext = 1; irq_timer = 1;
        rd("mip_both", 12'h344, 32'h880);
        irq_ext = 0; irq_timer = 0;
        cycle();
        do_reset();

        // Illegal instruction
        wr(12'h305, 32'h200);
        inst_valid = 1; pc = 32'h40; exp_code = 16'h0004;
        #1;
        chk("ill_kill", trap_kill, 1);
        cycle();
        idle();
        #1;
        chk("ill_redirect", redirect, 1);
        chk("ill_rpc", redirect_pc, 32'h200);
        rd("ill_mepc", 12'h341, 32'h40);
        rd("ill_mcause", 12'h342, 32'h2);
        rd("ill_mstatus", 12'h300, 32'h1800);
        cycle();
        chk("ill_redirect_once", redirect, 0);

        // MRET
        wr(12'h341, 32'h44);
        wr(12'h300, 32'h80);
        inst_valid = 1; is_mret = 1;
        #1;
        chk("mret_kill", trap_kill, 0);
        cycle();
        idle();
        #1;
        chk("mret_redirect", redirect, 1);
        chk("mret_rpc", redirect_pc, 32'h44);
        rd("mret_mstatus", 12'h300, 32'h1888);
        cycle();

        // Interrupt beats exception
        wr(12'h304, 32'h800);
        irq_ext = 1; inst_valid = 1; exp_code = 16'h0800; pc = 32'h80;
        #1;
        chk("irq_kill", trap_kill, 1);
        cycle();
        idle(); irq_ext = 0;
        #1;
        chk("irq_rpc", redirect_pc, 32'h200);
        rd("irq_mcause", 12'h342, 32'h8000_000B);
        rd("irq_mepc", 12'h341, 32'h80);
        cycle();

        // WFI woken by timer with MIE = 1
        wr(12'h300, 32'h8);
        wr(12'h304, 32'h80);
        inst_valid = 1; is_wfi = 1; pc = 32'h90;
        cycle();
        idle();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("wfi_stall", stall, 1);
            cycle();
        end
        irq_timer = 1;
        #1;
        chk("wfi_stall_last", stall, 1);
        cycle();
        #1;
        chk("wfi_wake_stall", stall, 0);
        chk("wfi_redirect", redirect, 1);
        chk("wfi_rpc", redirect_pc, 32'h200);
        rd("wfi_mepc", 12'h341, 32'h94);
        rd("wfi_mcause", 12'h342, 32'h8000_0007);
        irq_timer = 0;
        cycle();

        // WFI woken with MIE = 0: resume without redirect
        inst_valid = 1; is_wfi = 1; pc = 32'h90;
        cycle();
        idle();
        #1;
        chk("wfi0_stall", stall, 1);
        cycle();
        irq_timer = 1;
        cycle();
        #1;
        chk("wfi0_wake_stall", stall, 0);
        chk("wfi0_redirect", redirect, 0);
        rd("wfi0_mepc", 12'h341, 32'h94);
        irq_timer = 0;
        cycle();

        // CSR write colliding with an exception is dropped
        inst_valid = 1; csr_we = 1; csr_addr = 12'h305; csr_wdata = 32'h303;
        exp_code = 16'h0008; pc = 32'hA0;
        cycle();
        rd("coll_mtvec", 12'h305, 32'h200);
        rd("coll_mcause", 12'h342, 32'h3);
        cycle();
        wr(12'h305, 32'h303);
        rd("nocoll_mtvec", 12'h305, 32'h300);
        cycle();

        // Asynchronous reset while asleep
        inst_valid = 1; is_wfi = 1; pc = 32'hB0;
        cycle();
        idle();
        cycle();
        #1;
        chk("rstw_stall_before", stall, 1);
        #1;
        rst = 1;
        #1;
        chk("rstw_stall", stall, 0);
        chk("rstw_redirect", redirect, 0);
        rd("rstw_mtvec", 12'h305, 32'h100);
        rd("rstw_mstatus", 12'h300, 32'h1800);
        @(posedge clk);
        #1;
        rst = 0;
        m_reset();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int r;
            idle();
            inst_valid = ($urandom_range(0, 9) < 7);
            pc = $urandom & ~32'h3;
            r = $urandom_range(0, 19);
            if (r == 0) exp_code = 16'(1 << $urandom_range(0, 15));
            else if (r == 1) exp_code = 16'($urandom);
            is_mret   = ($urandom_range(0, 15) == 0);
            is_wfi    = ($urandom_range(0, 15) == 0);
            irq_ext   = ($urandom_range(0, 7) == 0);
            irq_timer = ($urandom_range(0, 7) == 0);
            csr_we    = ($urandom_range(0, 3) == 0);
            csr_addr  = addrs[$urandom_range(0, 6)];
            csr_wdata = $urandom;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer for the RV32I core. Takes the decode stage's exception code, `mret`/`wfi` flags and the external/timer interrupt lines, and owns the trap CSRs (mstatus, mie, mip, mtvec, mepc, mcause). It decides when a trap is taken, squashes the offending instruction, and redirects fetch to the handler or back to mepc. It also stalls the pipeline during WFI.

## Interface
- `RESET_MTVEC`, default 32'h0000_0000: mtvec value after reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inst_valid`  in  1  instruction in execute retires this cycle.
- `pc`  in  32  PC of that instruction.
- `exp_code`  in  16  one-hot exception bits from decode; bit index equals cause (2 illegal, 3 ebreak, 11 ecall).
- `is_mret`, `is_wfi`  in  1 each  decoded MRET / WFI.
- `irq_ext`, `irq_timer`  in  1 each  level-sensitive interrupt requests.
- `csr_we`  in  1  CSR write request.
- `csr_addr`  in  12  CSR address.
- `csr_wdata`  in  32  CSR write data.
- `csr_hit`  out  1  combinational; `csr_addr` is one of 0x300/0x304/0x305/0x341/0x342/0x344.
- `csr_rdata`  out  32  combinational read data; 0 when not hit.
- `trap_kill`  out  1  combinational; squash reg/mem write of the current instruction.
- `redirect`  out  1  registered; fetch must load `redirect_pc`.
- `redirect_pc`  out  32  target PC, valid while `redirect` = 1.
- `stall`  out  1  registered; hold the pipeline (WFI).

## Operation
- **CSR fields.** All other bits read 0 and ignore writes.
  - mstatus: MIE[3], MPIE[7]; MPP[12:11] reads 2'b11.
  - mie: MTIE[7], MEIE[11].
  - mip: read-only, MTIP[7] = `irq_timer`, MEIP[11] = `irq_ext`.
  - mtvec: direct mode only; bits[1:0] written as 0.
  - mepc: bits[1:0] written as 0.
  - mcause: full 32 bits writable.
- **Pending interrupt.** `pend` = (mip & mie) != 0. Global interrupt enable `gint` = pend & MIE. Ext beats timer: mcause 0x8000_000B over 0x8000_0007.
- **Priority at a retiring instruction (RUN, `inst_valid` = 1):**
  1. Interrupt (`gint`). The instruction is not executed; mepc ← pc.
  2. Exception (`exp_code` != 0). Lowest set bit index is the cause; mepc ← pc.
  3. MRET.
  4. WFI.
  5. CSR write.
- **Trap entry** (interrupt or exception): `trap_kill` = 1 in the same cycle. At the edge:
  - mcause ← cause; MPIE ← MIE; MIE ← 0; state ← REDIR.
  - redirect_pc ← mtvec.
- **MRET:** `trap_kill` = 0. At the edge: MIE ← MPIE; MPIE ← 1; redirect_pc ← mepc; state ← REDIR.
- **WFI:**
  - If `pend` is already 1, WFI acts as a NOP.
  - Otherwise state ← WAIT and `stall` = 1 from the next cycle.
- **CSR write:** applied at the edge only when `inst_valid` & `csr_we` & no trap/MRET this cycle. Writes to non-hit addresses are ignored.
- **States:**
  - RUN: normal operation.
  - REDIR:
    - `redirect` = 1 for exactly one cycle.
    - `inst_valid` is ignored, since the pipeline is flushing.
    - Next state is always RUN.
  - WAIT:
    - `stall` = 1; `inst_valid` is ignored.
    - When `pend` = 1: if MIE = 1, take the interrupt with mepc ← saved WFI pc + 4 and go to REDIR. Otherwise go to RUN and deassert `stall`.
- **Reset:**
  - State RUN; mtvec = `RESET_MTVEC`.
  - mstatus, mie, mepc, mcause and redirect_pc = 0.
  - `redirect` = `stall` = 0.
  - `trap_kill` = 0 whenever `inst_valid` = 0.
  - Reset mid-REDIR/WAIT returns to RUN immediately, with no redirect.

## Timing
- Trap or MRET detected in cycle N:
  - `trap_kill` is high in N.
  - `redirect` is high in N+1 only.
  - Fetch of the target is in N+1; the first handler instruction can retire at N+2 at the earliest.
- WFI retiring in cycle N: `stall` is high from N+1.
- WFI wake-up: when `pend` rises in cycle M, `stall` falls in M+1. On a taken interrupt, `redirect` is high in M+1.
- A CSR write in cycle N is visible on `csr_rdata` in N+1. A same-cycle read returns the old value.
- `irq_*` is sampled combinationally. The source must hold the level until it is acknowledged by software.
- Back-to-back: a trap in REDIR+1 (RUN again) is legal. Nesting re-saves MPIE ← 0.

## Test plan
- **Reset.** Assert `rst` mid-WAIT with `RESET_MTVEC` = 0x100 → `stall` drops asynchronously, `redirect` = 0, mtvec reads 0x100, mstatus reads 0x1800.
- **Illegal instruction.** `exp_code` = 0x0004, pc = 0x40, mtvec = 0x200 → `trap_kill` = 1 in the same cycle; next cycle `redirect` = 1, redirect_pc = 0x200; mepc = 0x40, mcause = 2, MIE = 0.
- **MRET.** MPIE = 1, mepc = 0x44, MRET retires → `redirect` next cycle to 0x44; mstatus shows MIE = 1, MPIE = 1.
- **Interrupt vs. exception.** MIE = 1, MEIE = 1, `irq_ext` = 1, together with ecall (0x0800) at pc 0x80 → mcause = 0x8000_000B, mepc = 0x80.
- **WFI.** MTIE = 1, MIE = 1, WFI at pc 0x90, `irq_timer` rising 5 cycles later → `stall` for 5 cycles, then redirect to mtvec, mepc = 0x94, mcause = 0x8000_0007. Repeat with MIE = 0 → `stall` drops, no redirect.
- **CSR write collision.** Write mtvec = 0x303 in the same cycle as `exp_code` = 0x0008 → the write is dropped and mcause = 3. Repeat without the exception → mtvec reads 0x300.
